// File: rtl/emu_pkg.sv
// Shared types and constants for the co-emulation transactor.
package emu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CAPT = 2'd2
  } emu_state_e;

  localparam int         STEP_W       = 8;
  localparam logic [7:0] READ_DEFAULT = 8'h00;

endpackage

// File: rtl/emu_step_ctrl.sv
// Step sequencer: runs the DUT for a host-given number of cycles through a
// clock enable, then optionally requests one capture cycle.
//
// state | meaning
// IDLE  | DUT frozen, accepting a new run request
// RUN   | dut_ce high, counter counting down to terminal count of 1
// CAPT  | DUT frozen, capture_strobe tells the top to latch dut_out
module emu_step_ctrl
  import emu_pkg::*;
#(
  parameter int AUTO_GET = 1
) (
  input  logic              clk_emu,
  input  logic              reset_emu,
  input  logic              start,
  input  logic [STEP_W-1:0] count,
  output logic              dut_ce,
  output logic              busy,
  output logic              capture_strobe
);

  emu_state_e        state_q, state_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;

  // State and down-counter registers.
  always_ff @(posedge clk_emu or posedge reset_emu) begin
    if (reset_emu) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter update and Moore outputs; outputs follow the state
  // register so a reset drops dut_ce/busy without waiting for a clock.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    dut_ce         = 1'b0;
    busy           = 1'b0;
    capture_strobe = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (count != '0)) begin
          cnt_d   = count;
          state_d = RUN;
        end
      end
      RUN: begin
        dut_ce = 1'b1;
        busy   = 1'b1;
        cnt_d  = cnt_q - STEP_W'(1);
        if (cnt_q == STEP_W'(1)) begin
          state_d = (AUTO_GET != 0) ? CAPT : IDLE;
        end
      end
      CAPT: begin
        busy           = 1'b1;
        capture_strobe = 1'b1;
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/emu_transactor.sv
// Co-emulation transactor: host byte port, stimulus/capture byte arrays and
// the stepped clock-enable interface towards the wrapped DUT.
module emu_transactor
  import emu_pkg::*;
#(
  parameter int NUM_STIM = 1,
  parameter int NUM_OUT  = 1,
  parameter int ADDR_W   = 3,
  parameter int AUTO_GET = 1
) (
  input  logic                  clk_emu,
  input  logic                  reset_emu,
  input  logic [7:0]            Din_emu,
  input  logic [ADDR_W-1:0]     Addr_emu,
  input  logic                  load_emu,
  input  logic                  get_emu,
  input  logic                  step_emu,
  output logic [7:0]            Dout_emu,
  output logic                  busy_emu,
  output logic [8*NUM_STIM-1:0] dut_in,
  input  logic [8*NUM_OUT-1:0]  dut_out,
  output logic                  dut_ce
);

  logic [7:0] stim_q [NUM_STIM];
  logic [7:0] vect_q [NUM_OUT];
  logic [7:0] rd_byte;
  logic       cmd_any;
  logic       do_load;
  logic       do_get;
  logic       do_start;
  logic       capture_strobe;

  // Any asserted command consumes the cycle, even one dropped while busy.
  assign cmd_any  = load_emu | get_emu | step_emu;
  assign do_load  = load_emu & ~busy_emu;
  assign do_get   = get_emu & ~load_emu & ~busy_emu;
  assign do_start = step_emu & ~load_emu & ~get_emu;

  emu_step_ctrl #(
    .AUTO_GET (AUTO_GET)
  ) u_step_ctrl (
    .clk_emu        (clk_emu),
    .reset_emu      (reset_emu),
    .start          (do_start),
    .count          (Din_emu),
    .dut_ce         (dut_ce),
    .busy           (busy_emu),
    .capture_strobe (capture_strobe)
  );

  // Capture-array read mux; addresses past NUM_OUT read the default byte.
  always_comb begin
    rd_byte = READ_DEFAULT;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (Addr_emu == ADDR_W'(k)) rd_byte = vect_q[k];
    end
  end

  // Host byte writes into the stimulus array; out-of-range addresses match nothing.
  always_ff @(posedge clk_emu or posedge reset_emu) begin
    if (reset_emu) begin
      for (int k = 0; k < NUM_STIM; k++) stim_q[k] <= 8'h00;
    end else if (!cmd_any) begin
      for (int k = 0; k < NUM_STIM; k++) begin
        if (Addr_emu == ADDR_W'(k)) stim_q[k] <= Din_emu;
      end
    end
  end

  // Registered host read data, refreshed only on plain byte-access cycles.
  always_ff @(posedge clk_emu or posedge reset_emu) begin
    if (reset_emu) begin
      Dout_emu <= 8'h00;
    end else if (!cmd_any) begin
      Dout_emu <= rd_byte;
    end
  end

  // Stimulus bus update on an accepted load.
  always_ff @(posedge clk_emu or posedge reset_emu) begin
    if (reset_emu) begin
      dut_in <= '0;
    end else if (do_load) begin
      for (int k = 0; k < NUM_STIM; k++) dut_in[8*k +: 8] <= stim_q[k];
    end
  end

  // Capture array: host get while idle, or the automatic capture after a run.
  always_ff @(posedge clk_emu or posedge reset_emu) begin
    if (reset_emu) begin
      for (int k = 0; k < NUM_OUT; k++) vect_q[k] <= 8'h00;
    end else if (do_get || capture_strobe) begin
      for (int k = 0; k < NUM_OUT; k++) vect_q[k] <= dut_out[8*k +: 8];
    end
  end

endmodule

// File: tb/tb_emu_transactor.sv
// Directed bench for emu_transactor (NUM_STIM=2, NUM_OUT=1, AUTO_GET=1).
module tb_emu_transactor;

  logic        clk_emu = 1'b0;
  logic        reset_emu;
  logic [7:0]  Din_emu;
  logic [2:0]  Addr_emu;
  logic        load_emu, get_emu, step_emu;
  logic [7:0]  Dout_emu;
  logic        busy_emu;
  logic [15:0] dut_in;
  logic [7:0]  dut_out;
  logic        dut_ce;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [7:0] ce_v, busy_v;

  emu_transactor #(
    .NUM_STIM (2),
    .NUM_OUT  (1),
    .ADDR_W   (3),
    .AUTO_GET (1)
  ) dut (
    .clk_emu   (clk_emu),
    .reset_emu (reset_emu),
    .Din_emu   (Din_emu),
    .Addr_emu  (Addr_emu),
    .load_emu  (load_emu),
    .get_emu   (get_emu),
    .step_emu  (step_emu),
    .Dout_emu  (Dout_emu),
    .busy_emu  (busy_emu),
    .dut_in    (dut_in),
    .dut_out   (dut_out),
    .dut_ce    (dut_ce)
  );

  always #5 clk_emu = ~clk_emu;

  task automatic tick();
    @(posedge clk_emu);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_emu = 1'b1;
    Din_emu   = 8'h00;
    Addr_emu  = 3'd0;
    load_emu  = 1'b0;
    get_emu   = 1'b0;
    step_emu  = 1'b0;
    dut_out   = 8'h0F;
    tick();
    tick();
    reset_emu = 1'b0;

    check("rst_dout", Dout_emu, 8'h00);
    check("rst_dut_in", dut_in, 16'h0000);
    check("rst_ce", dut_ce, 1'b0);
    check("rst_busy", busy_emu, 1'b0);

    // byte writes, out-of-range write, then load
    Addr_emu = 3'd0; Din_emu = 8'hA5; tick();
    Addr_emu = 3'd1; Din_emu = 8'h3C; tick();
    Addr_emu = 3'd2; Din_emu = 8'hFF; tick();
    load_emu = 1'b1; tick();
    load_emu = 1'b0;
    check("load_dut_in", dut_in, 16'h3CA5);

    // read before and after get, plus out-of-range read
    Addr_emu = 3'd0; Din_emu = 8'hA5; tick();
    check("read_pre_get", Dout_emu, 8'h00);
    get_emu = 1'b1; tick();
    get_emu = 1'b0;
    tick();
    check("read_after_get", Dout_emu, 8'h0F);
    Addr_emu = 3'd5; tick();
    check("read_oob", Dout_emu, 8'h00);

    // step of 4 with auto capture
    dut_out  = 8'h5A;
    Din_emu  = 8'd4; step_emu = 1'b1; tick();
    step_emu = 1'b0; Addr_emu = 3'd0; Din_emu = 8'hA5;
    ce_v = '0; busy_v = '0;
    for (int i = 1; i <= 8; i++) begin
      ce_v[i-1]   = dut_ce;
      busy_v[i-1] = busy_emu;
      if (i == 5) check("step4_dout_pre_capt", Dout_emu, 8'h0F);
      if (i == 7) check("step4_dout_post_capt", Dout_emu, 8'h5A);
      tick();
    end
    check("step4_ce_window", ce_v, 8'b0000_1111);
    check("step4_busy_window", busy_v, 8'b0001_1111);

    // step of 0 is a no-op
    Din_emu = 8'd0; step_emu = 1'b1; tick();
    step_emu = 1'b0;
    check("step0_ce", dut_ce, 1'b0);
    check("step0_busy", busy_emu, 1'b0);
    tick();
    check("step0_ce_later", dut_ce, 1'b0);
    check("step0_busy_later", busy_emu, 1'b0);

    // commands during a run of 5 are dropped; byte writes still land
    dut_out = 8'hC3;
    Addr_emu = 3'd1; Din_emu = 8'h77; tick();
    Din_emu = 8'd5; step_emu = 1'b1; tick();
    step_emu = 1'b0; Addr_emu = 3'd0; Din_emu = 8'hA5;
    ce_v = '0; busy_v = '0;
    for (int i = 1; i <= 8; i++) begin
      ce_v[i-1]   = dut_ce;
      busy_v[i-1] = busy_emu;
      load_emu = 1'b0; get_emu = 1'b0; step_emu = 1'b0;
      Addr_emu = 3'd0; Din_emu = 8'hA5;
      case (i)
        1: load_emu = 1'b1;
        2: get_emu = 1'b1;
        3: begin step_emu = 1'b1; Din_emu = 8'd9; dut_out = 8'hE1; end
        5: begin
          check("run_get_ignored", Dout_emu, 8'h5A);
          Addr_emu = 3'd1; Din_emu = 8'h66;
        end
        6: check("run_load_ignored", dut_in, 16'h3CA5);
        default: ;
      endcase
      tick();
    end
    load_emu = 1'b0; get_emu = 1'b0; step_emu = 1'b0;
    check("run5_ce_window", ce_v, 8'b0001_1111);
    check("run5_busy_window", busy_v, 8'b0011_1111);
    check("run5_auto_capture", Dout_emu, 8'hE1);
    load_emu = 1'b1; tick();
    load_emu = 1'b0;
    check("run5_write_landed", dut_in, 16'h66A5);

    // reset in the second cycle of a 10-cycle run
    Din_emu = 8'd10; step_emu = 1'b1; tick();
    step_emu = 1'b0; Addr_emu = 3'd0; Din_emu = 8'h00;
    tick();
    check("rst_run_ce_before", dut_ce, 1'b1);
    #2 reset_emu = 1'b1;
    #1;
    check("rst_run_ce", dut_ce, 1'b0);
    check("rst_run_busy", busy_emu, 1'b0);
    check("rst_run_dut_in", dut_in, 16'h0000);
    check("rst_run_dout", Dout_emu, 8'h00);
    tick();
    reset_emu = 1'b0;
    tick();
    check("rst_vect_cleared", Dout_emu, 8'h00);

    // fresh step of 3 after reset
    Din_emu = 8'd3; step_emu = 1'b1; tick();
    step_emu = 1'b0; Din_emu = 8'h00;
    ce_v = '0; busy_v = '0;
    for (int i = 1; i <= 6; i++) begin
      ce_v[i-1]   = dut_ce;
      busy_v[i-1] = busy_emu;
      tick();
    end
    check("step3_ce_window", ce_v, 8'b0000_0111);
    check("step3_busy_window", busy_v, 8'b0000_1111);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/emu_transactor.md
# emu_transactor

Parametrised co-emulation transactor that replaces the hand-written per-DUT wrapper bodies. It holds NUM_STIM host-writable stimulus bytes and NUM_OUT host-readable capture bytes, and drives a flattened stimulus bus into the DUT. It captures the DUT's flattened output bus. Unlike a free-running wrapper, it advances the DUT by a host-specified number of cycles through a clock-enable (`dut_ce`) and can auto-capture outputs at the end of each run. It sits between the MCU byte port and the DUT inside each `<dut>_wrapper`.

## Interface
Parameters:
- NUM_STIM, 1: number of stimulus bytes (1..2**ADDR_W).
- NUM_OUT, 1: number of capture bytes (1..2**ADDR_W).
- ADDR_W, 3: width of the host byte address.
- AUTO_GET, 1: when 1, a capture is performed automatically one cycle after each step run ends.

Ports:
- clk_emu  in  1  emulation clock; every register in the block uses its rising edge.
- reset_emu  in  1  asynchronous, active-high reset.
- Din_emu  in  8  host write data; also the step count when step_emu is asserted.
- Addr_emu  in  ADDR_W  host byte address.
- load_emu  in  1  copies the stimulus array to dut_in.
- get_emu  in  1  captures dut_out into the capture array.
- step_emu  in  1  starts a run of Din_emu DUT cycles.
- Dout_emu  out  8  registered host read data.
- busy_emu  out  1  high while a run or auto-capture is in progress.
- dut_in  out  8*NUM_STIM  stimulus bus; byte k corresponds to stimIn[k].
- dut_out  in  8*NUM_OUT  DUT output bus; byte k corresponds to vectOut[k].
- dut_ce  out  1  DUT clock enable, synchronous to clk_emu.

## Operation
- Reset values: Dout_emu, dut_in, dut_ce, busy_emu, every stimIn byte and every vectOut byte are 0. The FSM resets to IDLE.
- Command priority on each edge is load_emu > get_emu > step_emu > byte access. Exactly one action occurs per cycle.
- Byte access (no command asserted):
  - stimIn[Addr_emu] <= Din_emu.
  - Dout_emu <= vectOut[Addr_emu].
  - An address >= NUM_STIM discards the write.
  - An address >= NUM_OUT returns 8'h00.
  - Byte access is legal in any FSM state.
- load_emu: dut_in <= concatenation of stimIn. Load is accepted only in IDLE and ignored otherwise.
- get_emu: vectOut <= dut_out bytes. Get is accepted only in IDLE and ignored otherwise.
- step_emu: accepted only in IDLE with Din_emu != 0.
  - Loads the step counter with Din_emu and moves the FSM to RUN.
  - Din_emu == 0 is a no-op.
- FSM states:
  - IDLE: dut_ce = 0, busy_emu = 0.
  - RUN: dut_ce = 1, busy_emu = 1. The counter decrements each cycle. When the counter reaches 1, the next state is CAPT if AUTO_GET = 1, otherwise IDLE.
  - CAPT: dut_ce = 0, busy_emu = 1. vectOut <= dut_out, then the FSM returns to IDLE.
- Commands arriving while busy are dropped silently. Software polls busy_emu.

## Timing
- Byte write takes effect at the same edge it is presented. Dout_emu is valid 1 cycle after the address is presented.
- load_emu: dut_in changes at the sampling edge.
- Step sampled at edge t:
  - dut_ce is high for cycles t+1 .. t+N.
  - With AUTO_GET = 1, capture happens at edge t+N+1.
  - busy_emu is high for cycles t+1 .. t+N+1 (AUTO_GET = 1) or t+1 .. t+N (AUTO_GET = 0).
- The step counter is 8 bits. N = 255 gives 255 enabled cycles. There is no wrap-around.
- If reset_emu asserts mid-run, dut_ce and busy_emu drop immediately (asynchronously), the FSM returns to IDLE, and stimIn, vectOut and dut_in are cleared.
- If load_emu and step_emu are asserted in the same cycle, load wins and the step is lost.

## Structure
- Shared package emu_pkg holds:
  - the state enum (IDLE, RUN, CAPT);
  - the step-counter width constant (8);
  - the read-default constant (8'h00).
- Sub-module emu_step_ctrl contains the FSM and the step counter. Its inputs are start and count; its outputs are dut_ce, busy and capture_strobe.
- The top level owns the byte arrays and the host port.

## Test plan
- Write 8'hA5 to addr 0 and 8'h3C to addr 1 with NUM_STIM = 2, then pulse load -> dut_in == 16'h3CA5 at the next cycle.
- dut_out = 8'h0F, pulse get, then read addr 0 -> Dout_emu == 8'h0F one cycle later. Reading addr 5 with NUM_OUT = 1 -> 8'h00.
- Step with Din_emu = 4 at cycle t (AUTO_GET = 1) -> dut_ce high for exactly 4 cycles (t+1..t+4), vectOut updated at t+5, busy_emu low from t+6.
- Step with Din_emu = 0 -> dut_ce and busy_emu stay 0.
- During RUN, pulse load and get and step -> dut_in, vectOut and the run length are unchanged. A byte write during RUN still lands.
- Assert reset_emu at the 2nd cycle of a 10-cycle run -> dut_ce, busy_emu, dut_in and Dout_emu are 0 immediately. After release, a new step of 3 runs exactly 3 cycles.
